shift_serializer: RTL and testbench

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_bit_timer.sv | 40 ++++
 rtl/shift_serializer.sv | 132 +++++++++++++
 tb/tb_shift_serializer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift serializer and its bit timer.
package shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH = 8;
    localparam int   DEFAULT_DIV   = 1;
    localparam logic SOUT_IDLE     = 1'b0;

endpackage

// File: rtl/shift_bit_timer.sv
// Per-bit hold timer: counts 0..DIV-1 while running and ticks on the wrap cycle.
module shift_bit_timer
    import shift_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    // A one-bit counter is kept even for DIV=1 so the terminal compare stays legal.
    localparam int            TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TC = TW'(DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == TC);

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial converter with a one-entry holding buffer for gapless words.
//   state    | meaning
//   ST_IDLE  | nothing shifting; an accept (or a full buffer) loads the shifter
//   ST_SHIFT | a word is on sout; the next word may wait in the buffer
module shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int DIV       = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_data_q, buf_data_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    logic             tick;
    logic             timer_run;
    logic             timer_clr;
    logic             accept;
    logic             last_end;

    assign timer_run = (state_q == ST_SHIFT);
    assign timer_clr = (state_q == ST_IDLE);

    shift_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk  (clk),
        .rstn (rstn),
        .run  (timer_run),
        .clr  (timer_clr),
        .tick (tick)
    );

    // din_ready is a pure decode of a flop, so there is no path from din_valid.
    assign accept   = din_valid && !buf_full_q;
    assign last_end = (state_q == ST_SHIFT) && tick && (bit_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    shreg_d    = buf_data_q;
                    buf_full_d = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = ST_SHIFT;
                end else if (accept) begin
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (last_end) begin
                    bit_cnt_d = '0;
                    if (buf_full_q) begin
                        shreg_d    = buf_data_q;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        shreg_d = din;
                    end else begin
                        shreg_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (tick) begin
                        shreg_d   = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                                     : {1'b0, shreg_q[WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                    if (accept) begin
                        buf_data_d = din;
                        buf_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign sout_valid = (state_q == ST_SHIFT);
    assign sout       = sout_valid ? ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0])
                                   : SOUT_IDLE;
    assign sof        = sout_valid && (bit_cnt_q == '0);
    assign eof        = sout_valid && (bit_cnt_q == CNT_LAST);
    assign din_ready  = !buf_full_q;
    assign busy       = sout_valid || buf_full_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench: an MSB-first DIV=1 instance and an LSB-first DIV=3 instance.
module tb_shift_serializer;

    logic       clk;
    logic       rstn;

    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, sout, sout_valid, sof, eof, busy;

    logic [7:0] din2;
    logic       din_valid2;
    logic       din_ready2, sout2, sout_valid2, sof2, eof2, busy2;

    int n_cmp;
    int n_err;

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1), .DIV(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sof        (sof),
        .eof        (eof),
        .busy       (busy)
    );

    shift_serializer #(.WIDTH(8), .MSB_FIRST(0), .DIV(3)) dut_lsb (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din2),
        .din_valid  (din_valid2),
        .din_ready  (din_ready2),
        .sout       (sout2),
        .sout_valid (sout_valid2),
        .sof        (sof2),
        .eof        (eof2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rstn = 1'b0; din = '0; din_valid = 1'b0; din2 = '0; din_valid2 = 1'b0;
        #12;
        obs = {sout, sout_valid, sof, eof, busy, din_ready};
        n_cmp++;
        if (obs !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000001", obs);
        end
        obs = {sout2, sout_valid2, sof2, eof2, busy2, din_ready2};
        n_cmp++;
        if (obs !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_outputs_lsb: got %b want 000001", obs);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({sout, sout_valid, busy} !== 3'b000) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_single();
        logic [7:0] w = 8'hA5;
        logic [2:0] obs;
        din = w; din_valid = 1'b1;
        n_cmp++;
        if (din_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: got %b want 1", din_ready);
        end
        step();
        din_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            obs = {sout_valid, sof, eof};
            n_cmp++;
            if (obs !== {1'b1, k == 0, k == 7} || sout !== w[7-k]) begin
                n_err++;
                $display("FAIL single_bit%0d: got v/sof/eof=%b sout=%b want %b sout=%b",
                         k, obs, sout, {1'b1, k == 0, k == 7}, w[7-k]);
            end
            step();
        end
        n_cmp++;
        if (sout_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_end_idle: got valid=%b busy=%b want 0 0", sout_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream = 16'h0CF0;
        din = 8'h0C; din_valid = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) din = 8'hF0;
            if (k == 1) din_valid = 1'b0;
            n_cmp++;
            if (sout_valid !== 1'b1 || sout !== stream[15-k] ||
                din_ready !== (k == 0 || k >= 8)) begin
                n_err++;
                $display("FAIL b2b_cycle%0d: got valid=%b sout=%b ready=%b want 1 %b %b",
                         k, sout_valid, sout, din_ready, stream[15-k], (k == 0 || k >= 8));
            end
            step();
        end
        n_cmp++;
        if (sout_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end_idle: got valid=%b busy=%b want 0 0", sout_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words [3];
        logic [7:0] acc = '0;
        int idx = 0;
        int nfr = 0;
        bit acc_now;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        for (int cyc = 0; cyc < 40; cyc++) begin
            din       = (idx < 3) ? words[idx] : 8'h00;
            din_valid = (idx < 3);
            acc_now   = din_valid && din_ready;
            if (sout_valid) begin
                if (sof) acc = '0;
                acc = {acc[6:0], sout};
                if (eof) begin
                    n_cmp++;
                    if (nfr >= 3 || acc !== words[nfr]) begin
                        n_err++;
                        $display("FAIL bp_frame%0d: got %h want %h", nfr, acc,
                                 (nfr < 3) ? words[nfr] : 8'hxx);
                    end
                    nfr++;
                end
            end
            if (acc_now) idx++;
            step();
        end
        din_valid = 1'b0;
        n_cmp++;
        if (nfr != 3 || idx != 3) begin
            n_err++;
            $display("FAIL bp_counts: got frames=%0d accepts=%0d want 3 3", nfr, idx);
        end
    endtask

    task automatic test_lsb_div3();
        logic [2:0] obs;
        din2 = 8'h01; din_valid2 = 1'b1;
        step();
        din_valid2 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            obs = {sout_valid2, sof2, eof2};
            n_cmp++;
            if (obs !== {1'b1, k < 3, k >= 21} || sout2 !== (k < 3)) begin
                n_err++;
                $display("FAIL lsb_cycle%0d: got v/sof/eof=%b sout=%b want %b sout=%b",
                         k, obs, sout2, {1'b1, k < 3, k >= 21}, (k < 3));
            end
            step();
        end
        n_cmp++;
        if (sout_valid2 !== 1'b0 || busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL lsb_end_idle: got valid=%b busy=%b want 0 0", sout_valid2, busy2);
        end
    endtask

    task automatic test_reset_midword();
        logic [5:0] obs;
        int bad = 0;
        din = 8'hFF; din_valid = 1'b1;
        step();
        din = 8'h81;
        step();
        din_valid = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if (sout_valid !== 1'b1 || din_ready !== 1'b0 || sout !== 1'b1) begin
            n_err++;
            $display("FAIL rst_precond: got valid=%b ready=%b sout=%b want 1 0 1",
                     sout_valid, din_ready, sout);
        end
        #2;
        rstn = 1'b0;
        #1;
        obs = {sout, sout_valid, sof, eof, busy, din_ready};
        n_cmp++;
        if (obs !== 6'b000001) begin
            n_err++;
            $display("FAIL rst_midword: got %b want 000001", obs);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            if ({sout, sout_valid, busy} !== 3'b000) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rst_no_resume: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_lsb_div3();
        test_reset_midword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
